// File: rtl/pcr_chn_arb.sv
// pcr_chn_arb: packet-granular round-robin arbiter feeding one PCR
// correction path from CH_NUM buffered TS channels.
//
// Ports:
//   clk, rst            clock, async active-low reset
//   ch_pkt_rdy          per-channel "complete packet buffered"
//   ch_rd_req           one-cycle start pulse to the granted buffer
//   ch_sync/valid/data  per-channel byte stream (data: 8 bits/channel)
//   ch_cor_ena          per-channel correction enable
//   ts_sync/valid/data  muxed, registered stream to correction path
//   pcr_correct_ac_ena  correction enable latched per packet
//   ts_ch_id            source channel of current/last packet
//   pkt_err             one-cycle pulse on an aborted packet
//   busy                high in GRANT, XFER and DONE
module pcr_chn_arb #(
  parameter int CH_NUM  = 4,
  parameter int CH_W    = 2,
  parameter int PKT_LEN = 188,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH_NUM-1:0]   ch_pkt_rdy,
  output logic [CH_NUM-1:0]   ch_rd_req,
  input  logic [CH_NUM-1:0]   ch_sync,
  input  logic [CH_NUM-1:0]   ch_valid,
  input  logic [8*CH_NUM-1:0] ch_data,
  input  logic [CH_NUM-1:0]   ch_cor_ena,
  output logic                ts_sync,
  output logic                ts_valid,
  output logic [7:0]          ts_data,
  output logic                pcr_correct_ac_ena,
  output logic [CH_W-1:0]     ts_ch_id,
  output logic                pkt_err,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE, GRANT, XFER, DONE
  } state_t;

  state_t          state;
  logic [CH_W-1:0] g;
  logic [CH_W-1:0] last;
  logic [7:0]      cnt;
  logic [7:0]      tcnt;
  logic            nosync;

  logic [CH_W-1:0] nxt;
  logic [CH_W-1:0] idx;
  logic            hit;
  logic            sel_s;
  logic            sel_v;
  logic [7:0]      sel_d;
  logic            last_byte;
  logic            tmo_hit;

  // first requester strictly after the last-served channel, with wrap
  always_comb begin
    nxt = last;
    idx = '0;
    hit = 1'b0;
    for (int k = 1; k <= CH_NUM; k++) begin
      idx = CH_W'((int'(last) + k) % CH_NUM);
      if (!hit && ch_pkt_rdy[idx]) begin
        hit = 1'b1;
        nxt = idx;
      end
    end
  end

  assign sel_s     = ch_sync[g];
  assign sel_v     = ch_valid[g];
  assign sel_d     = ch_data[{g, 3'b000} +: 8];
  assign last_byte = (cnt == 8'(PKT_LEN - 1));
  assign tmo_hit   = (tcnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      g                  <= '0;
      last               <= CH_W'(CH_NUM - 1);
      cnt                <= '0;
      tcnt               <= '0;
      nosync             <= 1'b0;
      ch_rd_req          <= '0;
      ts_sync            <= 1'b0;
      ts_valid           <= 1'b0;
      ts_data            <= '0;
      pcr_correct_ac_ena <= 1'b0;
      ts_ch_id           <= '0;
      pkt_err            <= 1'b0;
      busy               <= 1'b0;
    end else begin
      ch_rd_req <= '0;
      pkt_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hit) begin
            g         <= nxt;
            ch_rd_req <= CH_NUM'(1) << nxt;
            busy      <= 1'b1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          // held through IDLE so the delayed correction stays aligned
          pcr_correct_ac_ena <= ch_cor_ena[g];
          ts_ch_id           <= g;
          state              <= XFER;
        end
        XFER: begin
          ts_data <= sel_d;
          if (sel_v) begin
            tcnt <= '0;
            if (cnt == '0 && !sel_s) begin
              // drain the packet silently so the buffer stays aligned
              pkt_err  <= 1'b1;
              nosync   <= 1'b1;
              ts_valid <= 1'b0;
              ts_sync  <= 1'b0;
              cnt      <= cnt + 1'b1;
              if (last_byte) state <= DONE;
            end else if (sel_s && cnt != '0 && !nosync) begin
              pkt_err  <= 1'b1;
              ts_valid <= 1'b0;
              ts_sync  <= 1'b0;
              state    <= DONE;
            end else begin
              ts_valid <= !nosync;
              ts_sync  <= sel_s & !nosync;
              cnt      <= cnt + 1'b1;
              if (last_byte) state <= DONE;
            end
          end else begin
            ts_valid <= 1'b0;
            ts_sync  <= 1'b0;
            tcnt     <= tcnt + 1'b1;
            // a silent (no-sync) packet already reported its error
            if (tmo_hit) begin
              pkt_err <= !nosync;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          last     <= g;
          cnt      <= '0;
          tcnt     <= '0;
          nosync   <= 1'b0;
          ts_valid <= 1'b0;
          ts_sync  <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcr_chn_arb.sv
// tb_pcr_chn_arb: table vectors, random packets against a packet-level
// model, plus hand sequences for reset behaviour.
module tb_pcr_chn_arb;

  localparam int N   = 4;
  localparam int W   = 2;
  localparam int LEN = 188;
  localparam int TO  = 255;

  localparam int M_NORM   = 0;
  localparam int M_NOSYNC = 1;
  localparam int M_EARLY  = 2;
  localparam int M_TMO    = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   ch_pkt_rdy;
  logic [N-1:0]   ch_rd_req;
  logic [N-1:0]   ch_sync;
  logic [N-1:0]   ch_valid;
  logic [8*N-1:0] ch_data;
  logic [N-1:0]   ch_cor_ena;
  logic           ts_sync;
  logic           ts_valid;
  logic [7:0]     ts_data;
  logic           pcr_correct_ac_ena;
  logic [W-1:0]   ts_ch_id;
  logic           pkt_err;
  logic           busy;

  int checks     = 0;
  int failures   = 0;
  int cyc        = 0;
  int model_last = N - 1;
  int prev_lastc = -100;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pcr_chn_arb #(
    .CH_NUM(N), .CH_W(W), .PKT_LEN(LEN), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ch_pkt_rdy(ch_pkt_rdy),
    .ch_rd_req(ch_rd_req),
    .ch_sync(ch_sync),
    .ch_valid(ch_valid),
    .ch_data(ch_data),
    .ch_cor_ena(ch_cor_ena),
    .ts_sync(ts_sync),
    .ts_valid(ts_valid),
    .ts_data(ts_data),
    .pcr_correct_ac_ena(pcr_correct_ac_ena),
    .ts_ch_id(ts_ch_id),
    .pkt_err(pkt_err),
    .busy(busy)
  );

  typedef struct {
    logic       v;
    logic       s;
    logic [7:0] d;
  } ent_t;

  typedef struct {
    logic [N-1:0] rdy;
    logic [N-1:0] ena;
    int           mode;
    int           p;
    int           off_at;
    bit           gaps;
    bit           gap_chk;
    int           exp_ch;
    bit           exp_ena;
    int           exp_err;
    int           exp_cnt;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [N-1:0] rdy,
                              input logic [N-1:0] ena, input int mode,
                              input int p, input int off_at,
                              input bit gaps, input bit gchk,
                              input int ch, input bit e_ena,
                              input int e_err, input int e_cnt);
    vec_t t;
    t.rdy = rdy; t.ena = ena; t.mode = mode; t.p = p;
    t.off_at = off_at; t.gaps = gaps; t.gap_chk = gchk;
    t.exp_ch = ch; t.exp_ena = e_ena; t.exp_err = e_err;
    t.exp_cnt = e_cnt;
    return t;
  endfunction

  task automatic wait_grant(output bit ok, output int g);
    ok = 1'b0;
    g  = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ch_rd_req != '0) begin
        ok = 1'b1;
        break;
      end
    end
    for (int c = 0; c < N; c++)
      if (ch_rd_req[c]) g = c;
  endtask

  task automatic drive(input int g, input logic v, input logic s,
                       input logic [7:0] d);
    logic [N-1:0] m;
    m        = N'(1) << g;
    ch_valid = (N'($urandom) & ~m) | (v ? m : '0);
    ch_sync  = (N'($urandom) & ~m) | (s ? m : '0);
    ch_data  = $urandom;
    ch_data[8*g +: 8] = d;
  endtask

  task automatic run_pkt(input vec_t t, input int seed);
    ent_t       st[$];
    logic [7:0] xb[$];
    logic [7:0] got[$];
    ent_t       en;
    bit         ok;
    int g, e, end_it, err_n, err_it, lastv_it;
    int firstc, lastc, bad, held, dmis;
    logic       sy;
    logic [7:0] d;
    e = 0;
    for (int i = 0; i < LEN; i++) begin
      if (t.mode == M_TMO && i >= t.p) break;
      if (t.gaps && i > 0)
        repeat ($urandom_range(0, 2)) st.push_back('{1'b0, 1'b0, 8'h00});
      sy = (i == 0 && t.mode != M_NOSYNC) ||
           (t.mode == M_EARLY && i == t.p);
      d  = (i == 0) ? 8'h47 : 8'(i - 1 + seed);
      if (t.mode == M_EARLY && i == t.p) e = st.size();
      st.push_back('{1'b1, sy, d});
      if (t.mode == M_NORM || t.mode == M_TMO ||
          (t.mode == M_EARLY && i < t.p))
        xb.push_back(d);
    end
    if (t.mode == M_NORM || t.mode == M_NOSYNC) e = st.size() - 1;
    if (t.mode == M_TMO) begin
      e = st.size() - 1 + TO;
      repeat (TO + 10) st.push_back('{1'b0, 1'b0, 8'h00});
    end

    ch_pkt_rdy = t.rdy;
    ch_cor_ena = t.ena;
    wait_grant(ok, g);
    check("grant", {59'd0, busy, ch_rd_req},
          {59'd0, 1'b1, N'(1) << t.exp_ch});
    if (!ok) g = t.exp_ch;

    end_it = -1; err_n = 0; err_it = -1; lastv_it = -1;
    firstc = -1; lastc = -1; bad = 0; held = 0; dmis = 0;
    for (int it = 0; it < 2000; it++) begin
      @(posedge clk);
      #1;
      if (it < st.size()) en = st[it];
      else en = '{1'b0, 1'b0, 8'h00};
      drive(g, en.v, en.s, en.d);
      if (it == t.off_at) ch_cor_ena = '0;
      @(negedge clk);
      if (ts_valid) begin
        if (ts_sync !== (got.size() == 0)) bad++;
        got.push_back(ts_data);
        lastv_it = it;
        lastc = cyc;
        if (firstc < 0) firstc = cyc;
      end else if (ts_sync) bad++;
      if (ch_rd_req != '0) bad++;
      if (pkt_err) begin
        err_n++;
        err_it = it;
      end
      if (ts_ch_id !== W'(t.exp_ch) ||
          pcr_correct_ac_ena !== t.exp_ena) held++;
      if (!busy) begin
        end_it = it;
        break;
      end
    end
    ch_valid = '0;
    ch_sync  = '0;

    for (int i = 0; i < got.size() && i < xb.size(); i++)
      if (got[i] !== xb[i]) dmis++;
    check("end_cycle", end_it, e + 2);
    check("fwd_count", got.size(), t.exp_cnt);
    check("fwd_data", bad + dmis, 0);
    check("pkt_err_count", err_n, t.exp_err);
    check("ena_id_held", held, 0);
    if (t.mode == M_TMO) check("timeout_gap", err_it - lastv_it, TO);
    if (t.gap_chk) check("pkt_gap", firstc - prev_lastc, 4);
    if (got.size() > 0) prev_lastc = lastc;
    model_last = t.exp_ch;
  endtask

  initial begin
    vec_t tbl[$];
    vec_t t;
    bit   ok;
    int   g, r;

    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(4'b1111, 4'b1010, M_NORM, 0, -1, 0, k > 0,
                       k % 4, (k % 2) == 1, 0, LEN));
    tbl.push_back(mk(4'b0100, 4'b0000, M_NORM,   0, -1, 0, 0, 2, 0, 0, LEN));
    tbl.push_back(mk(4'b0010, 4'b0010, M_NORM,   0, 50, 0, 0, 1, 1, 0, LEN));
    tbl.push_back(mk(4'b0001, 4'b0000, M_NORM,   0, -1, 0, 0, 0, 0, 0, LEN));
    tbl.push_back(mk(4'b1000, 4'b1000, M_NOSYNC, 0, -1, 0, 0, 3, 1, 1, 0));
    tbl.push_back(mk(4'b0010, 4'b0000, M_EARLY, 100, -1, 0, 0, 1, 0, 1, 100));
    tbl.push_back(mk(4'b0011, 4'b0001, M_TMO,   21, -1, 0, 0, 0, 1, 1, 21));
    tbl.push_back(mk(4'b0011, 4'b0000, M_NORM,   0, -1, 0, 0, 1, 0, 0, LEN));

    ch_pkt_rdy = '0;
    ch_valid   = '0;
    ch_sync    = '0;
    ch_data    = '0;
    ch_cor_ena = '0;
    #12;
    check("reset_state",
          {ch_rd_req, ts_sync, ts_valid, ts_data, pcr_correct_ac_ena,
           ts_ch_id, pkt_err, busy}, '0);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) run_pkt(tbl[i], 0);

    for (int n = 0; n < 30; n++) begin
      t.rdy  = N'($urandom_range(1, (1 << N) - 1));
      t.ena  = N'($urandom);
      r      = $urandom_range(0, 9);
      t.mode = (r < 6) ? M_NORM : (r == 6) ? M_NOSYNC :
               (r < 9) ? M_EARLY : M_TMO;
      t.p    = $urandom_range(1, LEN - 1);
      t.off_at  = -1;
      t.gaps    = 1'b1;
      t.gap_chk = 1'b0;
      t.exp_ch  = model_last;
      for (int k = 1; k <= N; k++)
        if (t.rdy[(model_last + k) % N]) begin
          t.exp_ch = (model_last + k) % N;
          break;
        end
      t.exp_ena = t.ena[t.exp_ch];
      t.exp_err = (t.mode == M_NORM) ? 0 : 1;
      t.exp_cnt = (t.mode == M_NORM) ? LEN :
                  (t.mode == M_NOSYNC) ? 0 : t.p;
      run_pkt(t, $urandom_range(0, 255));
    end

    ch_pkt_rdy = 4'b0100;
    wait_grant(ok, g);
    check("rst_seq_grant", ch_rd_req, 4'b0100);
    for (int i = 0; i < 90; i++) begin
      @(posedge clk);
      #1;
      drive(2, 1'b1, i == 0, (i == 0) ? 8'h47 : 8'(i - 1));
      @(negedge clk);
    end
    check("rst_seq_busy", {busy, ts_valid}, 2'b11);
    @(posedge clk);
    #1;
    drive(2, 1'b1, 1'b0, 8'd89);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset",
          {ch_rd_req, ts_sync, ts_valid, ts_data, pcr_correct_ac_ena,
           ts_ch_id, pkt_err, busy}, '0);
    ch_valid   = '0;
    ch_sync    = '0;
    ch_pkt_rdy = 4'b1111;
    repeat (3) @(negedge clk);
    check("reset_hold", {pkt_err, busy, ch_rd_req}, '0);
    rst = 1'b1;
    wait_grant(ok, g);
    check("post_reset_grant", ch_rd_req, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
